// File: rtl/debug_console_rx_pkg.sv
// Shared constants for the debug console receive side: register map, status layout
// and the encoding of characters handed over by the host.
package debug_console_rx_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int unsigned ST_VALID     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVR       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    localparam int unsigned DATA_EMPTY = 31;

    // Host getchar result: 0..255 is a character, any negative value means none pending.
    typedef logic signed [31:0] host_char_t;
    localparam host_char_t HOST_NO_CHAR = -32'sd1;

endpackage

// File: rtl/debug_console_rx_if.sv
// Read-only peripheral bus port of the console receiver plus the host character
// request/response pair used on each poll.
interface debug_console_rx_if
    import debug_console_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  adr_i;
    logic                  re_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  irq_o;
    logic                  getc_req_c;
    host_char_t            getc_char_i;

    modport slave (
        input  adr_i, re_i, getc_char_i,
        output dat_o, ack_o, irq_o, getc_req_c
    );

    modport master (
        output adr_i, re_i, getc_char_i,
        input  dat_o, ack_o, irq_o, getc_req_c
    );
endinterface

// File: rtl/debug_console_rx_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a look-ahead count for
// consumers that need a flag updated on the same edge as the count.
module debug_console_rx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_nxt_c,
    output logic [WIDTH-1:0]           head_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointer/count update; pushes when full and pops when empty are ignored.
    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;
    assign count_nxt_c = count_d;
    assign head_c      = mem_q[rd_ptr_q];

endmodule

// File: rtl/debug_console_rx.sv
// Debug console input: polls the host for keyboard characters at a fixed interval,
// buffers them and serves them through a two-register read-only bus slave.
module debug_console_rx
    import debug_console_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned POLL_INTERVAL = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    debug_console_rx_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

    logic [PW-1:0]         poll_cnt_q, poll_cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  ack_q, ack_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic                  poll_tick_c;
    logic                  getc_req_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  rd_data_c;
    logic                  rd_status_c;
    logic [31:0]           rd_word_c;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_nxt_c;
    logic [7:0]            fifo_head_c;

    debug_console_rx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_c),
        .data_i      (bus.getc_char_i[7:0]),
        .pop_i       (pop_c),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .count_nxt_c (fifo_count_nxt_c),
        .head_c      (fifo_head_c)
    );

    // Poll scheduling, host request, overrun tracking and read-data mux.
    always_comb begin
        poll_tick_c = (poll_cnt_q == '0);
        poll_cnt_d  = poll_tick_c ? POLL_RELOAD : poll_cnt_q - PW'(1);
        // A full FIFO skips the host call so the pending character stays with the host.
        getc_req_c  = poll_tick_c && !fifo_full && !rst_i;
        push_c      = getc_req_c && (bus.getc_char_i >= 0);

        rd_data_c   = bus.re_i && (bus.adr_i == REG_DATA);
        rd_status_c = bus.re_i && (bus.adr_i == REG_STATUS);
        pop_c       = rd_data_c && !fifo_empty;

        ovr_d = ovr_q;
        if (rd_status_c) begin
            ovr_d = 1'b0;
        end
        if (poll_tick_c && fifo_full) begin
            ovr_d = 1'b1;
        end

        rd_word_c = '0;
        if (rd_data_c) begin
            if (fifo_empty) begin
                rd_word_c[DATA_EMPTY] = 1'b1;
            end else begin
                rd_word_c[7:0] = fifo_head_c;
            end
        end else if (rd_status_c) begin
            rd_word_c[ST_VALID]           = !fifo_empty;
            rd_word_c[ST_FULL]            = fifo_full;
            rd_word_c[ST_OVR]             = ovr_q;
            rd_word_c[ST_COUNT_LSB +: 8]  = 8'(fifo_count);
        end

        dat_d = DATA_WIDTH'(rd_word_c);
        ack_d = bus.re_i;
        irq_d = (fifo_count_nxt_c != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            poll_cnt_q <= POLL_RELOAD;
            ovr_q      <= 1'b0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            ovr_q      <= ovr_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            dat_q      <= dat_d;
        end
    end

    assign bus.getc_req_c = getc_req_c;
    assign bus.dat_o      = dat_q;
    assign bus.ack_o      = ack_q;
    assign bus.irq_o      = irq_q;

endmodule

// File: tb/tb_debug_console_rx.sv
// Directed bench for debug_console_rx: a host stub queue answers the getchar polls
// and bus reads are compared against hand-computed register values.
module tb_debug_console_rx;
    import debug_console_rx_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PI    = 4;

    logic clk = 1'b0;
    logic rst;

    debug_console_rx_if #(.DATA_WIDTH(DW)) bus ();

    debug_console_rx #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .POLL_INTERVAL (PI)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] host_q [$];
    int dpi_calls     = 0;
    int n_push        = 0;
    int cyc           = 0;
    int last_call_cyc = 0;
    int n_vec         = 0;
    int n_err         = 0;

    // Host stub: consumes one queued character per request and counts every call.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.getc_req_c === 1'b1) begin
            dpi_calls     <= dpi_calls + 1;
            last_call_cyc <= cyc + 1;
            if (host_q.size() != 0) begin
                void'(host_q.pop_front());
                n_push <= n_push + 1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (host_q.size() != 0) bus.getc_char_i = host_char_t'(32'(host_q[0]));
        else                    bus.getc_char_i = HOST_NO_CHAR;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a read at the current negedge; returns data one cycle later with ack checked.
    task automatic bus_rd(input logic adr, output logic [31:0] data);
        bus.adr_i = adr;
        bus.re_i  = 1'b1;
        @(negedge clk);
        bus.re_i = 1'b0;
        chk_eq("rd_ack", 32'(bus.ack_o), 32'd1);
        data = bus.dat_o;
    endtask

    task automatic wait_push(input int target, input string tag);
        int guard = 0;
        while (n_push < target && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (n_push < target) chk_eq(tag, 32'(n_push), 32'(target));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n0, c0, l0, idx, guard;
        logic [7:0] exp6 [48];

        rst = 1'b1;
        bus.adr_i = REG_DATA;
        bus.re_i  = 1'b0;
        host_q.push_back(8'h41);
        repeat (5) @(negedge clk);
        chk_eq("rst_ack", 32'(bus.ack_o), 32'd0);
        chk_eq("rst_irq", 32'(bus.irq_o), 32'd0);
        chk_eq("rst_dat", bus.dat_o, 32'd0);
        chk_eq("rst_calls", 32'(dpi_calls), 32'd0);

        // 1) poll cadence and first push
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk_eq("t1_calls_pre", 32'(dpi_calls), 32'd0);
                chk_eq("t1_irq_pre", 32'(bus.irq_o), 32'd0);
            end
            if (i == 4) begin
                chk_eq("t1_calls_first", 32'(dpi_calls), 32'd1);
                chk_eq("t1_irq_first", 32'(bus.irq_o), 32'd1);
            end
        end
        chk_eq("t1_calls_16", 32'(dpi_calls), 32'd4);
        bus_rd(REG_STATUS, d);
        chk_eq("t1_status", d, 32'h0000_0101);

        // 2) DATA pop, then empty read
        bus_rd(REG_DATA, d);
        chk_eq("t2_data", d, 32'h0000_0041);
        chk_eq("t2_irq", 32'(bus.irq_o), 32'd0);
        bus_rd(REG_DATA, d);
        chk_eq("t2_empty", d, 32'h8000_0000);
        bus_rd(REG_STATUS, d);
        chk_eq("t2_status", d, 32'h0000_0000);
        @(negedge clk);
        chk_eq("t2_ack_drop", 32'(bus.ack_o), 32'd0);

        // 3) fill to full, overrun, drain in order
        n0 = n_push;
        c0 = dpi_calls;
        for (int i = 0; i < 20; i++) host_q.push_back(8'(i));
        wait_push(n0 + 16, "t3_fill_timeout");
        repeat (20) @(negedge clk);
        chk_eq("t3_calls_full", 32'(dpi_calls - c0), 32'd16);
        chk_eq("t3_host_left", 32'(host_q.size()), 32'd4);
        chk_eq("t3_irq_full", 32'(bus.irq_o), 32'd1);
        guard = 0;
        while (((cyc - last_call_cyc) % PI) != 0 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        bus_rd(REG_STATUS, d);
        chk_eq("t3_status_ovr", d, 32'h0000_1007);
        bus_rd(REG_STATUS, d);
        chk_eq("t3_status_clr", d, 32'h0000_1003);
        for (int i = 0; i < 20; i++) begin
            bus_rd(REG_DATA, d);
            chk_eq("t3_drain", d, 32'(i));
        end
        chk_eq("t3_irq_drained", 32'(bus.irq_o), 32'd0);
        chk_eq("t3_pushes", 32'(n_push - n0), 32'd20);
        chk_eq("t3_host_empty", 32'(host_q.size()), 32'd0);
        bus_rd(REG_STATUS, d);
        chk_eq("t3_status_end", d, 32'h0000_0000);

        // 4) push and pop on the same edge at count=3, then back-to-back reads
        n0 = n_push;
        host_q.push_back(8'hA0);
        host_q.push_back(8'hA1);
        host_q.push_back(8'hA2);
        wait_push(n0 + 3, "t4_fill_timeout");
        host_q.push_back(8'hA3);
        l0 = last_call_cyc;
        repeat (3) @(negedge clk);
        bus_rd(REG_DATA, d);
        chk_eq("t4_old_head", d, 32'h0000_00A0);
        chk_eq("t4_push_same_edge", 32'(last_call_cyc - l0), 32'(PI));
        chk_eq("t4_pushes", 32'(n_push - n0), 32'd4);
        bus_rd(REG_STATUS, d);
        chk_eq("t4_count3", d, 32'h0000_0301);
        for (int i = 1; i < 4; i++) begin
            bus_rd(REG_DATA, d);
            chk_eq("t4_b2b_data", d, 32'(8'hA0 + i));
        end
        @(negedge clk);
        chk_eq("t4_ack_drop", 32'(bus.ack_o), 32'd0);
        chk_eq("t4_irq", 32'(bus.irq_o), 32'd0);

        // 5) reset with count=5 and a read in flight
        n0 = n_push;
        for (int i = 0; i < 5; i++) host_q.push_back(8'(8'h30 + i));
        wait_push(n0 + 5, "t5_fill_timeout");
        bus.adr_i = REG_DATA;
        bus.re_i  = 1'b1;
        rst = 1'b1;
        host_q.push_back(8'h55);
        c0 = dpi_calls;
        @(negedge clk);
        bus.re_i = 1'b0;
        chk_eq("t5_ack_dropped", 32'(bus.ack_o), 32'd0);
        chk_eq("t5_irq_rst", 32'(bus.irq_o), 32'd0);
        repeat (8) @(negedge clk);
        chk_eq("t5_calls_in_rst", 32'(dpi_calls), 32'(c0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("t5_calls_pre", 32'(dpi_calls), 32'(c0));
        @(negedge clk);
        chk_eq("t5_calls_restart", 32'(dpi_calls), 32'(c0 + 1));
        chk_eq("t5_irq_restart", 32'(bus.irq_o), 32'd1);
        bus_rd(REG_STATUS, d);
        chk_eq("t5_status", d, 32'h0000_0101);
        bus_rd(REG_DATA, d);
        chk_eq("t5_data", d, 32'h0000_0055);

        // 6) pointer wrap over 3*DEPTH characters with interleaved reads
        n0 = n_push;
        for (int i = 0; i < 48; i++) begin
            exp6[i] = 8'(i * 7 + 3);
            host_q.push_back(exp6[i]);
        end
        wait_push(n0 + 10, "t6_fill_timeout");
        idx = 0;
        guard = 0;
        while (idx < 48 && guard < 1000) begin
            bus_rd(REG_DATA, d);
            if (d[DATA_EMPTY] == 1'b0) begin
                chk_eq("t6_wrap_data", d, 32'(exp6[idx]));
                idx++;
            end
            bus_rd(REG_STATUS, d);
            chk_eq("t6_cnt_le_depth", 32'(d[15:8] <= 8'(DEPTH)), 32'd1);
            chk_eq("t6_no_ovr", 32'(d[ST_OVR]), 32'd0);
            guard++;
        end
        chk_eq("t6_received", 32'(idx), 32'd48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
